vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and pixel output stage, driven from the 50 MHz board clock. Derives the pixel clock enable, generates HS/VS/BLANK_N with configurable geometry and sync polarity, and exports pixel X/Y to an upstream pixel source. Registers the returned RGB onto the VGA DAC pins. Replaces fixed-geometry timing logic in top-level VGA designs.

Parameters:
CLK_DIV, 2, CLOCK_50 cycles per pixel; even, >=2
H_SYNC, 96, HS pulse width in pixels
H_BP, 48, horizontal back porch in pixels
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
V_SYNC, 2, VS pulse width in lines
V_BP, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
HS_POL, 0, HS asserted level (0 = active-low)
VS_POL, 0, VS asserted level (0 = active-low)

Ports:
CLOCK_50  in  1  system clock, all logic on posedge
RESET_N  in  1  synchronous active-low reset
IN_R, IN_G, IN_B  in  8 each  pixel colour for the X/Y presented one pixel earlier
PIX_X  out  11  active-area column, 0 outside active
PIX_Y  out  10  active-area row, 0 outside active
PIX_ACTIVE  out  1  PIX_X/PIX_Y address a visible pixel
FRAME_START  out  1  one CLOCK_50 pulse at h=0,v=0
VGA_CLK  out  1  pixel clock to DAC
VGA_HS, VGA_VS  out  1 each  sync outputs
VGA_BLANK_N  out  1  low outside visible area
VGA_SYNC_N  out  1  constant 0
VGA_R, VGA_G, VGA_B  out  8 each  DAC colour

Behaviour:
- Reset is synchronous, active-low; the polarity and synchronicity are fixed.
- H_TOTAL = sum of H params (default 800); V_TOTAL = sum of V params (default 525). Region order per line/frame: sync, back porch, active, front porch.
- div_cnt counts 0..CLK_DIV-1; pix_ce asserted when div_cnt == CLK_DIV-1. VGA_CLK registered = (div_cnt >= CLK_DIV/2); falls at pix_ce boundary, so DAC samples on the VGA_CLK rising edge mid-pixel.
- On pix_ce: h_cnt increments and wraps at H_TOTAL-1 to 0. On h wrap, v_cnt increments and wraps at V_TOTAL-1 to 0. No counting without pix_ce.
- Stage 0 (registered on pix_ce from next counter values): PIX_ACTIVE = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v in corresponding V range. PIX_X = h-(H_SYNC+H_BP), PIX_Y = v-(V_SYNC+V_BP) when active, else 0.
- Stage 1 (next pix_ce): VGA_HS = HS_POL when h<H_SYNC else ~HS_POL (delayed one pixel); VGA_VS likewise from v<V_SYNC; VGA_BLANK_N = delayed PIX_ACTIVE. VGA_R/G/B = IN_* sampled when delayed active, else 0. Sync/blank/RGB are mutually aligned, one pixel after X/Y; upstream has one full pixel period to return colour.
- FRAME_START: single CLOCK_50 cycle high on the pix_ce where counters become h=0,v=0.
- Reset: counters, div_cnt, pipeline cleared; VGA_CLK 0, HS/VS at deasserted level, BLANK_N 0, RGB 0, PIX_* 0, FRAME_START 0. Reset mid-line restarts geometry from h=0,v=0; first pix_ce CLK_DIV cycles after RESET_N rises; no partial sync pulse is emitted during reset.
- Widths: counters 11/10 bits; parameters yielding H_TOTAL > 2048 or V_TOTAL > 1024 are illegal.

Optional Feature:
VGA_PATTERN_EN: adds input PATTERN_SEL (1 bit). When 1, IN_* are ignored and colour comes from 8 vertical bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black; full-scale 8'hFF/8'h00 components), selected by delayed PIX_X. Pipeline alignment unchanged. Without the macro the port and generator are absent and IN_* pass through.

Test Plan:
- Defaults, reset released -> VGA_HS period 1600 CLOCK_50 cycles, low for 192 cycles; VGA_VS period 840000 cycles, low for 3200 cycles.
- Defaults -> VGA_BLANK_N high for exactly 1280 cycles per visible line, 480 lines per frame; first high 288 cycles after HS falling edge.
- IN_R driven = PIX_X[7:0] -> VGA_R at each BLANK_N-high pixel equals column index (0,1,...,255,0,...) with no offset.
- RESET_N low for 10 cycles at h=400,v=200 -> outputs at reset values during reset; after release, first HS assertion within CLK_DIV+1 cycles; FRAME_START pulses once.
- CLK_DIV=4, H 8/4/16/4, V 1/1/4/1 -> HS period 128 cycles, VS period 896 cycles, VGA_CLK 50% duty.
- VGA_PATTERN_EN, PATTERN_SEL=1 -> PIX 0..79 RGB FF/FF/FF, 80..159 FF/FF/00, 560..639 00/00/00.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// VGA raster timing generator and pixel output stage. It runs on the 50 MHz
// board clock and derives a pixel clock enable from it. It produces
// HS/VS/BLANK_N with configurable geometry and sync polarity. It exports the
// active-area pixel coordinate to an upstream pixel source, and registers the
// colour that source returns onto the VGA DAC pins.
//
// Optional build feature: define VGA_PATTERN_EN to add the PATTERN_SEL input
// and an internal 8-bar colour test pattern generator.
//
// Ports
//   CLOCK_50     in   1   system clock, every register on its rising edge
//   RESET_N      in   1   synchronous active-low reset
//   IN_R/G/B     in   8   colour for the PIX_X/PIX_Y presented one pixel ago
//   PATTERN_SEL  in   1   (VGA_PATTERN_EN only) 1 = colour bars replace IN_*
//   PIX_X        out  11  active-area column, 0 outside the active area
//   PIX_Y        out  10  active-area row, 0 outside the active area
//   PIX_ACTIVE   out  1   PIX_X/PIX_Y address a visible pixel
//   FRAME_START  out  1   one CLOCK_50 pulse when the raster reaches h=0,v=0
//   VGA_CLK      out  1   pixel clock to the DAC
//   VGA_HS/VS    out  1   sync outputs, asserted level set by HS_POL/VS_POL
//   VGA_BLANK_N  out  1   low outside the visible area
//   VGA_SYNC_N   out  1   tied low (no sync-on-green)
//   VGA_R/G/B    out  8   DAC colour
//
// Geometry limits: counters are 11 bits (h) and 10 bits (v), so
// H_TOTAL must not exceed 2048 and V_TOTAL must not exceed 1024.
// CLK_DIV must be even and at least 2.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [7:0]  IN_R,
  input  logic [7:0]  IN_G,
  input  logic [7:0]  IN_B,
`ifdef VGA_PATTERN_EN
  input  logic        PATTERN_SEL,
`endif
  output logic [10:0] PIX_X,
  output logic [9:0]  PIX_Y,
  output logic        PIX_ACTIVE,
  output logic        FRAME_START,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // VGA_CLK is high for the second half of each pixel, so it falls together
  // with the pixel enable and the DAC latches on its rising edge mid-pixel.
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BP + H_ACTIVE);

  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

`ifdef VGA_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  // Bar number 0..7 for an active-area column. Uses threshold compares
  // rather than a divider because BAR_W need not be a power of two.
  function automatic logic [2:0] bar_index(input logic [10:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= BAR_W * 11'(i)) idx = 3'(i);
    end
    return idx;
  endfunction

  // Bar order white, yellow, cyan, green, magenta, red, blue, black:
  // red is off for bars 2,3,6,7, green for 4..7, blue for the odd bars.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction
`endif

  // Timebase state
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             pix_ce;
  logic             vga_clk;
  logic [10:0]      h_cnt;
  logic [10:0]      h_next;
  logic [9:0]       v_cnt;
  logic [9:0]       v_next;
  logic             frame_start;
  logic             active_next;

  // Stage 0: coordinate presented to the pixel source
  logic             vld_p0;
  logic [10:0]      x_p0;
  logic [9:0]       y_p0;

  // Stage 1: sync, blank and colour presented to the DAC
  logic             hs_p1;
  logic             vs_p1;
  logic             vld_p1;
  logic [7:0]       r_p1;
  logic [7:0]       g_p1;
  logic [7:0]       b_p1;

  logic [7:0]       src_r;
  logic [7:0]       src_g;
  logic [7:0]       src_b;

  always_comb begin
    pix_ce   = (div_cnt == DIV_LAST);
    div_next = pix_ce ? '0 : div_cnt + 1'b1;
    h_next   = h_cnt;
    v_next   = v_cnt;
    if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_next = 11'd0;
        v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 11'd1;
      end
    end
    active_next = (h_next >= H_ACT_START) && (h_next < H_ACT_END) &&
                  (v_next >= V_ACT_START) && (v_next < V_ACT_END);
  end

  // Colour source for stage 1: the upstream pixel or the built-in bars.
  always_comb begin
    src_r = IN_R;
    src_g = IN_G;
    src_b = IN_B;
`ifdef VGA_PATTERN_EN
    if (PATTERN_SEL) {src_r, src_g, src_b} = bar_colour(bar_index(x_p0));
`endif
  end

  // ---- timebase: divider, raster counters, frame marker ----
  // Reset clears the counters to h=0,v=0, so a reset mid-line restarts the
  // raster from the top-left. The first pixel enable comes CLK_DIV clocks
  // after release.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      div_cnt     <= '0;
      vga_clk     <= 1'b0;
      h_cnt       <= 11'd0;
      v_cnt       <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      vga_clk     <= (div_next >= DIV_HALF);
      frame_start <= pix_ce && (h_next == 11'd0) && (v_next == 10'd0);
      if (pix_ce) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
      end
    end
  end

  // ---- stage 0: coordinate of the pixel the counters now point at ----
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      vld_p0 <= 1'b0;
      x_p0   <= 11'd0;
      y_p0   <= 10'd0;
    end else if (pix_ce) begin
      vld_p0 <= active_next;
      x_p0   <= active_next ? h_next - H_ACT_START : 11'd0;
      y_p0   <= active_next ? v_next - V_ACT_START : 10'd0;
    end
  end

  // ---- stage 1: outputs for the pixel addressed during the last period ----
  // Sync is decoded from the pre-increment counters, so it lines up with the
  // colour returned for the coordinate that stage 0 was showing.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      hs_p1  <= ~HS_POL;
      vs_p1  <= ~VS_POL;
      vld_p1 <= 1'b0;
      r_p1   <= 8'd0;
      g_p1   <= 8'd0;
      b_p1   <= 8'd0;
    end else if (pix_ce) begin
      hs_p1  <= (h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
      vs_p1  <= (v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
      vld_p1 <= vld_p0;
      r_p1   <= vld_p0 ? src_r : 8'd0;
      g_p1   <= vld_p0 ? src_g : 8'd0;
      b_p1   <= vld_p0 ? src_b : 8'd0;
    end
  end

  assign PIX_X       = x_p0;
  assign PIX_Y       = y_p0;
  assign PIX_ACTIVE  = vld_p0;
  assign FRAME_START = frame_start;
  assign VGA_CLK     = vga_clk;
  assign VGA_HS      = hs_p1;
  assign VGA_VS      = vs_p1;
  assign VGA_BLANK_N = vld_p1;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_p1;
  assign VGA_G       = g_p1;
  assign VGA_B       = b_p1;

endmodule
